seq_detector_core: RTL and testbench

SEQ_DETECTOR_CORE -- requirements
Module: seq_detector

---
 rtl/seq_detector_pkg.sv | 48 ++++
 rtl/seq_detector_core.sv | 55 +++++
 tb/tb_seq_detector_core.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial sequence detector: the state encoding,
// the sequence length, the default pattern and the prefix fallback function.
package seq_detector_pkg;

  localparam int SEQ_LEN = 12;
  localparam logic [SEQ_LEN-1:0] DEFAULT_PATTERN = 12'h123;

  // Sk: the last k sampled bits equal the first k bits of the pattern.
  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
  } state_t;

  // Longest prefix of `pattern` that is also a suffix of the matched prefix of
  // length k followed by the new bit b. Bits are consumed MSB first. All loops
  // have constant bounds, so the function unrolls into plain compare logic.
  function automatic logic [3:0] kmp_next(input logic [SEQ_LEN-1:0] pattern,
                                          input logic [3:0]         k,
                                          input logic               b);
    logic [SEQ_LEN:0] hist;   // hist[i] is the i-th bit in arrival order
    logic [3:0]       best;
    logic [3:0]       pidx;
    logic [3:0]       hidx;
    logic             hit;
    hist = '0;
    best = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      pidx = 4'(SEQ_LEN - 1 - i);
      if (i < int'(k)) hist[i] = pattern[pidx];
    end
    hist[k] = b;
    // Ascending search: the last hit is the longest prefix.
    for (int j = 1; j <= SEQ_LEN; j++) begin
      if (j <= int'(k) + 1) begin
        hit = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) begin
          if (i < j) begin
            pidx = 4'(SEQ_LEN - 1 - i);
            hidx = 4'(int'(k) + 1 - j + i);
            if (pattern[pidx] != hist[hidx]) hit = 1'b0;
          end
        end
        if (hit) best = 4'(j);
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_core.sv
// Serial Moore sequence detector with a registered match flag.
// The out flag is high exactly while the FSM sits in S12.
// Optional feature macro: SEQ_DET_OVERLAP_EN. When it is defined, matches
// may overlap. When it is undefined, the bit after a match starts a fresh
// search from S0.
module seq_detector_core
  import seq_detector_pkg::*;
#(
  parameter int                 SEQ_LEN = seq_detector_pkg::SEQ_LEN,  // fixed at 12
  parameter logic [SEQ_LEN-1:0] PATTERN = seq_detector_pkg::DEFAULT_PATTERN
) (
  output logic out,
  input  logic seq,
  input  logic clk,
  input  logic reset
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] k_eff;
  logic [3:0] next_if_0;
  logic [3:0] next_if_1;

  // Next state: prefix fallback from the current matched length.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    k_eff = 4'(state_q);
`ifndef SEQ_DET_OVERLAP_EN
    if (state_q == S12) k_eff = 4'd0;
`endif
    next_if_0 = kmp_next(PATTERN, k_eff, 1'b0);
    next_if_1 = kmp_next(PATTERN, k_eff, 1'b1);
    // If seq is X/Z, (seq ^ seq) is unknown and the else branch runs. That
    // branch takes the shorter continuation, which acts as a mismatch. In
    // hardware the test is always true, so this reduces to a 2:1 mux.
    if ((seq ^ seq) == 1'b0) begin
      state_d = state_t'(seq ? next_if_1 : next_if_0);
    end else begin
      state_d = state_t'((next_if_0 < next_if_1) ? next_if_0 : next_if_1);
    end
  end

  // State register and the registered Moore output, both cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      out     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      state_q <= state_d;
      out     <= (state_d == S12);
    end
  end

endmodule

// File: tb/tb_seq_detector_core.sv
// Self-checking bench for seq_detector_core. It uses a window/count reference
// model, directed cases and randomized streams.
module tb_seq_detector_core;

  localparam logic [11:0] PAT = 12'h123;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk;
  logic reset;
  logic seq;
  logic out;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model: the last 12 bits and the number of bits eligible to match.
  logic [11:0] hist;
  int          cnt;
  logic        exp_out;

  seq_detector_core #(.PATTERN(PAT)) dut (
    .out   (out),
    .seq   (seq),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a match is the last 12 bits equal to PAT, with all 12 bits counted
  // since reset. Without overlap, the bits of a match cannot be reused.
  task automatic model_bit(input logic b);
    hist = {hist[10:0], b};
    cnt++;
    exp_out = (cnt >= 12) && (hist == PAT);
    if (exp_out && !OVERLAP) cnt = 0;
  endtask

  // Called at a negedge: drive the bit, let the DUT sample it, then check at
  // the following negedge.
  task automatic step(input logic b);
    seq = b;
    @(posedge clk);
    model_bit(b);
    @(negedge clk);
    check("stream", {31'd0, out}, {31'd0, exp_out});
    if (out) pulses++;
  endtask

  task automatic send_word(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) step(w[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_async_out", {31'd0, out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_out", {31'd0, out}, 32'd0);
    reset   = 1'b1;
    hist    = '0;
    cnt     = 0;
    exp_out = 1'b0;
    pulses  = 0;
  endtask

  initial begin
    logic [11:0] w;
    logic [11:0] half;
    reset = 1'b0;
    seq   = 1'b0;
    hist  = '0;
    cnt   = 0;
    exp_out = 1'b0;
    @(negedge clk);
    apply_reset();

    // Exact pattern: the pulse comes only on the 12th edge, then clears.
    send_word(PAT);
    check("exact_hit", {31'd0, out}, 32'd1);
    check("exact_pulses", pulses, 1);
    step(1'b0);
    check("exact_clear", {31'd0, out}, 32'd0);

    // Reset asserted while out is high must clear out without a clock edge.
    apply_reset();
    send_word(PAT);
    check("pre_async_hit", {31'd0, out}, 32'd1);
    #2;
    apply_reset();

    // Shifted versions of the pattern never match.
    send_word(PAT << 1);
    send_word(12'h000);
    check("shl_no_hit", pulses, 0);
    apply_reset();
    send_word(PAT >> 1);
    send_word(12'h000);
    check("shr_no_hit", pulses, 0);

    // Partial progress is discarded by reset.
    apply_reset();
    half = PAT;
    for (int i = 11; i >= 6; i--) step(half[i]);
    apply_reset();
    send_word(PAT);
    check("post_rst_hit", {31'd0, out}, 32'd1);
    check("post_rst_pulses", pulses, 1);

    // Back-to-back patterns: two pulses.
    apply_reset();
    send_word(PAT);
    check("b2b_first", {31'd0, out}, 32'd1);
    send_word(PAT);
    check("b2b_second", {31'd0, out}, 32'd1);
    check("b2b_pulses", pulses, 2);

    // Leading zeros exercise the fallback: a single pulse at the end.
    apply_reset();
    for (int i = 0; i < 11; i++) step(1'b0);
    send_word(PAT);
    check("fallback_hit", {31'd0, out}, 32'd1);
    check("fallback_pulses", pulses, 1);

    // Randomized mix: exact patterns, single-bit near misses, random words,
    // and an occasional reset.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: w = PAT;
        1: w = PAT ^ (12'd1 << $urandom_range(0, 11));
        default: w = 12'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) apply_reset();
      send_word(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
